// File: rtl/sprite_pkg.sv
// Shared constants and FSM state type for the sprite fetch scheduler.
package sprite_pkg;

  localparam int SPRITE_W = 41;
  localparam int SPRITE_H = 65;
  localparam int ADDR_W   = 12;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_P  = 2'd1,
    RD_N  = 2'd2,
    CAP_N = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/sprite_addr_calc.sv
// Per-lane box test, horizontal mirror and ROM address for one sprite.
module sprite_addr_calc
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 41,
  parameter int SPRITE_H = 65
) (
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        org_x,
  input  logic [9:0]        org_y,
  input  logic              flip,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  logic [10:0]       x_end;
  logic [10:0]       y_end;
  logic [9:0]        dx;
  logic [9:0]        dy;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr_full;

  // Box edges are formed in 11 bits so sprites near the right/bottom border never wrap.
  always_comb begin
    x_end     = {1'b0, org_x} + 11'(SPRITE_W);
    y_end     = {1'b0, org_y} + 11'(SPRITE_H);
    hit       = ({1'b0, draw_x} >= {1'b0, org_x}) && ({1'b0, draw_x} < x_end) &&
                ({1'b0, draw_y} >= {1'b0, org_y}) && ({1'b0, draw_y} < y_end);
    dx        = draw_x - org_x;
    dy        = draw_y - org_y;
    col       = flip ? (ADDR_W'(SPRITE_W - 1) - ADDR_W'(dx)) : ADDR_W'(dx);
    addr_full = (ADDR_W'(dy) * ADDR_W'(SPRITE_W)) + col;
    // A missed lane presents address 0 so the shared ROM sees a defined value.
    addr      = hit ? addr_full : '0;
  end

endmodule

// File: rtl/sprite_fetch_sched.sv
// Schedules two sprite ROM reads (player then NPC) per pixel request over a
// shared single-port ROM with a fixed four-cycle request-to-result latency.
module sprite_fetch_sched
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = sprite_pkg::SPRITE_H
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_req,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        Player_X,
  input  logic [9:0]        Player_Y,
  input  logic [9:0]        NPC_X,
  input  logic [9:0]        NPC_Y,
  input  logic              player_flip,
  input  logic              npc_flip,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  player_idx,
  output logic [IDX_W-1:0]  npc_idx,
  output logic              player_hit,
  output logic              npc_hit,
  output logic              pix_valid,
  output logic              busy
);

  fetch_state_t      state;
  fetch_state_t      next_state;
  logic              accept;
  logic              p_hit;
  logic              n_hit;
  logic [ADDR_W-1:0] p_addr;
  logic [ADDR_W-1:0] n_addr;
  logic [ADDR_W-1:0] npc_addr_p0;

  sprite_addr_calc #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_player (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .org_x  (Player_X),
    .org_y  (Player_Y),
    .flip   (player_flip),
    .hit    (p_hit),
    .addr   (p_addr)
  );

  sprite_addr_calc #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_npc (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .org_x  (NPC_X),
    .org_y  (NPC_Y),
    .flip   (npc_flip),
    .hit    (n_hit),
    .addr   (n_addr)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; requests arriving outside IDLE are dropped, not queued.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (pix_req) begin
          accept     = 1'b1;
          next_state = RD_P;
        end
      end
      RD_P:    next_state = RD_N;
      RD_N:    next_state = CAP_N;
      CAP_N:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Stage p0: NPC address held from acceptance until its ROM slot in RD_P.
  always_ff @(posedge Clk) begin
    if (accept) npc_addr_p0 <= n_addr;
  end

  // Result registers: ROM address sequencing, hit flags, captured indices, valid pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr   <= '0;
      player_hit <= 1'b0;
      npc_hit    <= 1'b0;
      player_idx <= '0;
      npc_idx    <= '0;
      pix_valid  <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rom_addr   <= p_addr;
            player_hit <= p_hit;
            npc_hit    <= n_hit;
          end
        end
        RD_P: rom_addr <= npc_addr_p0;
        // Player data returns the cycle after the ROM sampled its address.
        RD_N: player_idx <= player_hit ? rom_data : '0;
        CAP_N: begin
          npc_idx   <= npc_hit ? rom_data : '0;
          pix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
